qed_decoder_pipe: RTL and testbench

Parametrised, buffered successor to the QED combinational decoder. It accepts LANES RISC-V instructions per beat over a valid/ready handshake. Each lane is decoded into register fields, a sign-preserving 12-bit immediate and a QED class (R/I/LW/SW/NONE), and the result is held in a BUF_DEPTH-entry FIFO. It sits between instruction fetch/duplication logic and the QED transform stage, decoupling back-pressure between them.

---
 rtl/qed_decoder_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_qed_decoder_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_decoder_pipe.sv
// Buffered QED instruction decoder: LANES RV instructions per beat, decoded then held in a BUF_DEPTH FIFO.
// Optional statistics counters are built when QED_DEC_STATS_EN is defined.
module qed_decoder_pipe #(
  parameter int LANES     = 2,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_instr,
  input  logic [LANES-1:0]      in_lane_vld,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_vld,
  output logic [3*LANES-1:0]    out_class,
  output logic [5*LANES-1:0]    out_rd,
  output logic [5*LANES-1:0]    out_rs1,
  output logic [5*LANES-1:0]    out_rs2,
  output logic [12*LANES-1:0]   out_imm12,
  output logic [3*LANES-1:0]    out_funct3
`ifdef QED_DEC_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [CNT_W-1:0]      cnt_r,
  output logic [CNT_W-1:0]      cnt_i,
  output logic [CNT_W-1:0]      cnt_lw,
  output logic [CNT_W-1:0]      cnt_sw
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);

  localparam logic [2:0] CLS_NONE = 3'd0;
  localparam logic [2:0] CLS_R    = 3'd1;
  localparam logic [2:0] CLS_I    = 3'd2;
  localparam logic [2:0] CLS_LW   = 3'd3;
  localparam logic [2:0] CLS_SW   = 3'd4;

  if (LANES < 1 || BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_err
    $error("qed_decoder_pipe: illegal parameter combination");
  end

  function automatic logic [2:0] decode_class(input logic [31:0] ins);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = ins[6:0];
    f7 = ins[31:25];
    f3 = ins[14:12];
    decode_class = CLS_NONE;
    case (op)
      7'b0110011:
        if (f7 == 7'b0000000 || f7 == 7'b0000001 ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
          decode_class = CLS_R;
      7'b0111011:
        if ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
            (f7 == 7'b0000001 && (f3 == 3'b000 || f3 >= 3'b100)))
          decode_class = CLS_R;
      7'b0010011:
        if (f3 != 3'b001 && f3 != 3'b101) decode_class = CLS_I;
      7'b0011011:
        if (f3 == 3'b000) decode_class = CLS_I;
      7'b0000011:
        if (f3 == 3'b010) decode_class = CLS_LW;
      7'b0100011:
        if (f3 == 3'b010) decode_class = CLS_SW;
      default: decode_class = CLS_NONE;
    endcase
  endfunction

  logic [3*LANES-1:0]  dec_class;
  logic [5*LANES-1:0]  dec_rd, dec_rs1, dec_rs2;
  logic [12*LANES-1:0] dec_imm;
  logic [3*LANES-1:0]  dec_f3;

  // Masked-off lanes store all-zero fields so the buffer contents stay deterministic.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] ins;
    logic [2:0]  cls;
    logic        v;
    assign ins = in_instr[32*l +: 32];
    assign v   = in_lane_vld[l];
    assign cls = v ? decode_class(ins) : CLS_NONE;
    assign dec_class[3*l +: 3]  = cls;
    assign dec_rd[5*l +: 5]     = v ? ins[11:7]  : 5'd0;
    assign dec_rs1[5*l +: 5]    = v ? ins[19:15] : 5'd0;
    assign dec_rs2[5*l +: 5]    = v ? ins[24:20] : 5'd0;
    assign dec_f3[3*l +: 3]     = v ? ins[14:12] : 3'd0;
    assign dec_imm[12*l +: 12]  = !v ? 12'd0 :
                                  (cls == CLS_SW) ? {ins[31:25], ins[11:7]} : ins[31:20];
  end

  logic [LANES-1:0]    mem_vld   [BUF_DEPTH];
  logic [3*LANES-1:0]  mem_class [BUF_DEPTH];
  logic [5*LANES-1:0]  mem_rd    [BUF_DEPTH];
  logic [5*LANES-1:0]  mem_rs1   [BUF_DEPTH];
  logic [5*LANES-1:0]  mem_rs2   [BUF_DEPTH];
  logic [12*LANES-1:0] mem_imm   [BUF_DEPTH];
  logic [3*LANES-1:0]  mem_f3    [BUF_DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign in_ready  = (count != (AW+1)'(BUF_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < BUF_DEPTH; e++) begin
        mem_vld[e]   <= '0;
        mem_class[e] <= '0;
        mem_rd[e]    <= '0;
        mem_rs1[e]   <= '0;
        mem_rs2[e]   <= '0;
        mem_imm[e]   <= '0;
        mem_f3[e]    <= '0;
      end
    end else if (push) begin
      mem_vld[wr_ptr]   <= in_lane_vld;
      mem_class[wr_ptr] <= dec_class;
      mem_rd[wr_ptr]    <= dec_rd;
      mem_rs1[wr_ptr]   <= dec_rs1;
      mem_rs2[wr_ptr]   <= dec_rs2;
      mem_imm[wr_ptr]   <= dec_imm;
      mem_f3[wr_ptr]    <= dec_f3;
    end
  end

  assign out_lane_vld = mem_vld[rd_ptr];
  assign out_class    = mem_class[rd_ptr];
  assign out_rd       = mem_rd[rd_ptr];
  assign out_rs1      = mem_rs1[rd_ptr];
  assign out_rs2      = mem_rs2[rd_ptr];
  assign out_imm12    = mem_imm[rd_ptr];
  assign out_funct3   = mem_f3[rd_ptr];

`ifdef QED_DEC_STATS_EN
  localparam int NW = $clog2(LANES + 1);
  localparam int SW = CNT_W + NW;

  logic [NW-1:0] n_r, n_i, n_lw, n_sw;

  always_comb begin
    n_r  = '0;
    n_i  = '0;
    n_lw = '0;
    n_sw = '0;
    for (int l = 0; l < LANES; l++) begin
      if (out_lane_vld[l]) begin
        case (out_class[3*l +: 3])
          CLS_R:   n_r  = n_r  + NW'(1);
          CLS_I:   n_i  = n_i  + NW'(1);
          CLS_LW:  n_lw = n_lw + NW'(1);
          CLS_SW:  n_sw = n_sw + NW'(1);
          default: ;
        endcase
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [NW-1:0] n);
    logic [SW-1:0] s;
    s = SW'(c) + SW'(n);
    sat_add = (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Counters keep running across flush; a popped entry in a flush cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0; cnt_i <= '0; cnt_lw <= '0; cnt_sw <= '0;
    end else if (stats_clr) begin
      cnt_r <= '0; cnt_i <= '0; cnt_lw <= '0; cnt_sw <= '0;
    end else if (pop) begin
      cnt_r  <= sat_add(cnt_r,  n_r);
      cnt_i  <= sat_add(cnt_i,  n_i);
      cnt_lw <= sat_add(cnt_lw, n_lw);
      cnt_sw <= sat_add(cnt_sw, n_sw);
    end
  end
`endif

endmodule

// File: tb/tb_qed_decoder_pipe.sv
// Self-checking bench for qed_decoder_pipe: queue-based reference model plus directed literal checks.
module tb_qed_decoder_pipe;
  localparam int LANES = 2;
  localparam int DEPTH = 2;
`ifdef QED_DEC_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [32*LANES-1:0]  in_instr;
  logic [LANES-1:0]     in_lane_vld, out_lane_vld;
  logic [3*LANES-1:0]   out_class, out_funct3;
  logic [5*LANES-1:0]   out_rd, out_rs1, out_rs2;
  logic [12*LANES-1:0]  out_imm12;
`ifdef QED_DEC_STATS_EN
  logic stats_clr;
  logic [CNT_W-1:0] cnt_r, cnt_i, cnt_lw, cnt_sw;
`endif

  qed_decoder_pipe #(.LANES(LANES), .BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_lane_vld(in_lane_vld),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
    .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm12(out_imm12), .out_funct3(out_funct3)
`ifdef QED_DEC_STATS_EN
    , .stats_clr(stats_clr), .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_lw(cnt_lw), .cnt_sw(cnt_sw)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written directly from the class rules.
  function automatic int exp_class(input logic [31:0] i);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = i[6:0]; f7 = i[31:25]; f3 = i[14:12];
    if (op == 7'b0110011 && (f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}))) return 1;
    if (op == 7'b0111011 && ((f7 == 7'h00 && f3 inside {3'd0, 3'd1, 3'd5}) ||
                             (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) ||
                             (f7 == 7'h01 && f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7}))) return 1;
    if (op == 7'b0010011 && f3 inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7}) return 2;
    if (op == 7'b0011011 && f3 == 3'd0) return 2;
    if (op == 7'b0000011 && f3 == 3'd2) return 3;
    if (op == 7'b0100011 && f3 == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic [11:0] exp_imm(input logic [31:0] i);
    return (exp_class(i) == 4) ? {i[31:25], i[11:7]} : i[31:20];
  endfunction

  typedef struct packed {
    logic [32*LANES-1:0] ins;
    logic [LANES-1:0]    mask;
  } beat_t;

  beat_t q[$];
  int m_cnt[1:4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int c = 1; c <= 4; c++) m_cnt[c] = 0;
    end else begin
      bit do_pop, do_push;
      beat_t b;
      do_pop  = (q.size() != 0) && out_ready;
      do_push = in_valid && (q.size() < DEPTH) && !flush;
`ifdef QED_DEC_STATS_EN
      if (stats_clr) begin
        for (int c = 1; c <= 4; c++) m_cnt[c] = 0;
      end else if (do_pop) begin
        for (int l = 0; l < LANES; l++) begin
          int c;
          c = exp_class(q[0].ins[32*l +: 32]);
          if (q[0].mask[l] && c != 0 && m_cnt[c] < CMAX) m_cnt[c]++;
        end
      end
`endif
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          b.ins = in_instr; b.mask = in_lane_vld;
          q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      if (q.size() != 0) begin
        for (int l = 0; l < LANES; l++) begin
          logic [31:0] ins;
          bit v;
          ins = q[0].ins[32*l +: 32];
          v   = q[0].mask[l];
          chk($sformatf("lane%0d_vld", l), 32'(out_lane_vld[l]), 32'(v));
          chk($sformatf("lane%0d_class", l), 32'(out_class[3*l +: 3]), v ? exp_class(ins) : 0);
          if (v) begin
            chk($sformatf("lane%0d_rd", l),  32'(out_rd[5*l +: 5]),  32'(ins[11:7]));
            chk($sformatf("lane%0d_rs1", l), 32'(out_rs1[5*l +: 5]), 32'(ins[19:15]));
            chk($sformatf("lane%0d_rs2", l), 32'(out_rs2[5*l +: 5]), 32'(ins[24:20]));
            chk($sformatf("lane%0d_f3", l),  32'(out_funct3[3*l +: 3]), 32'(ins[14:12]));
            chk($sformatf("lane%0d_imm", l), 32'(out_imm12[12*l +: 12]), 32'(exp_imm(ins)));
          end
        end
      end
`ifdef QED_DEC_STATS_EN
      chk("cnt_r", 32'(cnt_r), m_cnt[1]);
      chk("cnt_i", 32'(cnt_i), m_cnt[2]);
      chk("cnt_lw", 32'(cnt_lw), m_cnt[3]);
      chk("cnt_sw", 32'(cnt_sw), m_cnt[4]);
`endif
    end
  end

  task automatic set_in(input logic v, input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] m);
    in_valid = v; in_instr = {i1, i0}; in_lane_vld = m;
  endtask

  // Push one beat with the consumer stalled, leaving it at the head.
  task automatic push_hold(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] m);
    out_ready = 1'b0;
    set_in(1'b1, i0, i1, m);
    @(posedge clk); @(negedge clk);
    set_in(1'b0, 32'd0, 32'd0, 2'b00);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] t_i0[6];
  logic [31:0] t_i1[6];
  logic [1:0]  t_m[6];

  initial begin
    t_i0 = '{32'h002081B3, 32'h4000103B, 32'h0200103B, 32'h0000101B, 32'h00002023, 32'h00A00293};
    t_i1 = '{32'h40005033, 32'h02004033, 32'h00001013, 32'h00003003, 32'h0200703B, 32'h4000503B};
    t_m  = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b11, 2'b10};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 2'b00);
`ifdef QED_DEC_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_out_imm12", 32'(out_imm12), 0);

    // R + I beat, visible the cycle after acceptance
    push_hold(32'h002081B3, 32'h00A00293, 2'b11);
    chk("t1_l0_class", 32'(out_class[2:0]), 1);
    chk("t1_l0_rd", 32'(out_rd[4:0]), 3);
    chk("t1_l0_rs1", 32'(out_rs1[4:0]), 1);
    chk("t1_l0_rs2", 32'(out_rs2[4:0]), 2);
    chk("t1_l1_class", 32'(out_class[5:3]), 2);
    chk("t1_l1_rd", 32'(out_rd[9:5]), 5);
    chk("t1_l1_imm", 32'(out_imm12[23:12]), 32'h00A);
    pop_one();

    // LW + SW beat
    push_hold(32'h00412303, 32'h00712423, 2'b11);
    chk("t2_l0_class", 32'(out_class[2:0]), 3);
    chk("t2_l0_rd", 32'(out_rd[4:0]), 6);
    chk("t2_l0_rs1", 32'(out_rs1[4:0]), 2);
    chk("t2_l0_imm", 32'(out_imm12[11:0]), 32'h004);
    chk("t2_l1_class", 32'(out_class[5:3]), 4);
    chk("t2_l1_rs1", 32'(out_rs1[9:5]), 2);
    chk("t2_l1_rs2", 32'(out_rs2[9:5]), 7);
    chk("t2_l1_imm", 32'(out_imm12[23:12]), 32'h008);
    pop_one();

    // ecall decodes to NONE; masked lane 1 also NONE
    push_hold(32'h00000073, 32'h002081B3, 2'b01);
    chk("t3_l0_class", 32'(out_class[2:0]), 0);
    chk("t3_l1_class", 32'(out_class[5:3]), 0);
    chk("t3_l1_vld", 32'(out_lane_vld[1]), 0);
    pop_one();

    // back-pressure: third beat stalls while the FIFO is full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, t_i0[k], t_i1[k], t_m[k]);
      @(posedge clk); @(negedge clk);
    end
    chk("stall_in_ready", 32'(in_ready), 0);
    @(posedge clk); @(negedge clk);
    chk("stall_head_rd", 32'(out_rd[4:0]), 3);
    chk("stall_head_class", 32'(out_class[5:3]), 1);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("unstall_in_ready", 32'(in_ready), 1);
    @(posedge clk); @(negedge clk);
    set_in(1'b0, 32'd0, 32'd0, 2'b00);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("drain_out_valid", 32'(out_valid), 0);

    // streaming: one beat per cycle, occupancy stays 1
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_in(1'b1, t_i0[k], t_i1[k], t_m[k]);
      @(posedge clk); @(negedge clk);
      chk("stream_out_valid", 32'(out_valid), 1);
      chk("stream_in_ready", 32'(in_ready), 1);
    end
    set_in(1'b0, 32'd0, 32'd0, 2'b00);
    @(posedge clk); @(negedge clk);
    chk("stream_end_valid", 32'(out_valid), 0);

    // flush beats a same-cycle push
    push_hold(t_i0[3], t_i1[3], t_m[3]);
    set_in(1'b1, t_i0[4], t_i1[4], t_m[4]);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 2'b00);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    @(posedge clk); @(negedge clk);
    chk("flush_drop_valid", 32'(out_valid), 0);

    // asynchronous reset mid-stream clears entries and storage
    push_hold(32'h002081B3, 32'h00A00293, 2'b11);
    rst_n = 1'b0;
    #2;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    chk("mrst_out_class", 32'(out_class), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef QED_DEC_STATS_EN
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 32'h002081B3, 32'h002081B3, 2'b11);
      @(posedge clk); @(negedge clk);
    end
    set_in(1'b0, 32'd0, 32'd0, 2'b00);
    @(posedge clk); @(negedge clk);
    chk("stats_cnt_r_sat", 32'(cnt_r), 3);
    chk("stats_cnt_i", 32'(cnt_i), 0);
    push_hold(32'h002081B3, 32'h00A00293, 2'b11);
    out_ready = 1'b1;
    stats_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    stats_clr = 1'b0;
    out_ready = 1'b0;
    chk("stats_clr_cnt_r", 32'(cnt_r), 0);
    chk("stats_clr_cnt_i", 32'(cnt_i), 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
